// File: rtl/bit_population_generator.sv
// rtl/bit_population_generator.sv - enumerates all WIDTH-bit words with k bits set, ascending.
// Optional abort input enabled by defining BIT_POP_GEN_ABORT_EN.
module bit_population_generator #(
  parameter int WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [$clog2(WIDTH):0] cnt_i,
  input  logic                   cnt_val_i,
  output logic                   cnt_ready_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   data_val_o,
  output logic                   data_last_o,
  input  logic                   data_ready_i
`ifdef BIT_POP_GEN_ABORT_EN
  ,
  input  logic                   abort_i
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] last_word;

  logic [CW-1:0]    k;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] final_word;

  always_comb begin
    k          = (cnt_i > CW'(WIDTH)) ? CW'(WIDTH) : cnt_i;
    first_word = WIDTH'((ONE << k) - ONE);
    final_word = first_word << (CW'(WIDTH) - k);
  end

  // Gosper's hack carried out one bit wider so t+1 cannot wrap at the MSB
  logic [WIDTH:0]   v;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   t_inc;
  logic [WIDTH:0]   low;
  logic [SW-1:0]    tz;
  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] next_word;

  always_comb begin
    v     = {1'b0, data_o};
    t     = v | (v - ONE);
    t_inc = t + ONE;
    low   = (~t & t_inc) - ONE;
    tz    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_o[i]) tz = SW'(i);
    end
    sh        = tz + SW'(1);
    next_word = WIDTH'(t_inc | (low >> sh));
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state       <= IDLE;
      cnt_ready_o <= 1'b1;
      data_val_o  <= 1'b0;
      data_last_o <= 1'b0;
      data_o      <= '0;
      last_word   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt_val_i) begin
            state       <= RUN;
            cnt_ready_o <= 1'b0;
            data_val_o  <= 1'b1;
            data_o      <= first_word;
            last_word   <= final_word;
            data_last_o <= (first_word == final_word);
          end
        end
        RUN: begin
`ifdef BIT_POP_GEN_ABORT_EN
          if (abort_i) begin
            state       <= IDLE;
            cnt_ready_o <= 1'b1;
            data_val_o  <= 1'b0;
            data_last_o <= 1'b0;
          end else
`endif
          if (data_val_o && data_ready_i) begin
            if (data_last_o) begin
              state       <= IDLE;
              cnt_ready_o <= 1'b1;
              data_val_o  <= 1'b0;
              data_last_o <= 1'b0;
            end else begin
              data_o      <= next_word;
              data_last_o <= (next_word == last_word);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_population_generator.sv
// tb/tb_bit_population_generator.sv - scoreboard bench for bit_population_generator (WIDTH 16 and 4).
module tb_bit_population_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic [4:0]  cnt;
  logic        cnt_val;
  logic        cnt_ready;
  logic [15:0] data;
  logic        val;
  logic        last;
  logic        ready;

  logic [2:0]  cnt4;
  logic        cnt_val4;
  logic        cnt_ready4;
  logic [3:0]  data4;
  logic        val4;
  logic        last4;
  logic        ready4;

`ifdef BIT_POP_GEN_ABORT_EN
  logic abort;
  logic abort4;
`endif

  bit_population_generator #(.WIDTH(16)) dut (
    .clk_i(clk), .srst_i(srst), .cnt_i(cnt), .cnt_val_i(cnt_val),
    .cnt_ready_o(cnt_ready), .data_o(data), .data_val_o(val),
    .data_last_o(last), .data_ready_i(ready)
`ifdef BIT_POP_GEN_ABORT_EN
    , .abort_i(abort)
`endif
  );

  bit_population_generator #(.WIDTH(4)) dut4 (
    .clk_i(clk), .srst_i(srst), .cnt_i(cnt4), .cnt_val_i(cnt_val4),
    .cnt_ready_o(cnt_ready4), .data_o(data4), .data_val_o(val4),
    .data_last_o(last4), .data_ready_i(ready4)
`ifdef BIT_POP_GEN_ABORT_EN
    , .abort_i(abort4)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] word;
    logic        last;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference enumeration by brute force over all 16-bit values
  task automatic push_model(input int k);
    int kk;
    kk = (k > 16) ? 16 : k;
    for (int v = 0; v < 65536; v++) begin
      if ($countones(v[15:0]) == kk) q.push_back('{word: v[15:0], last: 1'b0});
    end
    q[q.size() - 1].last = 1'b1;
  endtask

  // cut_mode: 0 none, 1 async reset at word index cut_at, 2 abort at word index cut_at
  task automatic run_seq(input int k, input bit rand_ready, input bit keep_val,
                         input int cut_at, input int cut_mode);
    exp_t        e;
    int          idx = 0;
    int          budget = 0;
    int          kk;
    bit          done = 0;
    bit          stalled = 0;
    bit          have_prev = 0;
    logic [15:0] held = '0;
    logic [15:0] prev = '0;
    kk = (k > 16) ? 16 : k;
    check("idle_ready", 32'(cnt_ready), 1);
    check("idle_val", 32'(val), 0);
    cnt     = 5'(k);
    cnt_val = 1'b1;
    push_model(k);
    @(negedge clk);
    if (!keep_val) cnt_val = 1'b0;
    check("first_latency", 32'(val), 1);
    while (!done && budget < 40000) begin
      budget++;
      if (keep_val) cnt = 5'($urandom_range(0, 20));
      if (stalled) begin
        check("stall_data", 32'(data), 32'(held));
        check("stall_val", 32'(val), 1);
      end
      if (val) begin
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ready) begin
          e = q.pop_front();
          check("word", 32'(data), 32'(e.word));
          check("last", 32'(last), 32'(e.last));
          check("popcount", $countones(data), kk);
          if (have_prev) check("ascending", 32'(data > prev), 1);
          prev      = data;
          have_prev = 1;
          stalled   = 0;
          if (e.last || (cut_mode != 0 && idx == cut_at)) done = 1;
          idx++;
        end else begin
          stalled = 1;
          held    = data;
        end
      end else begin
        check("val_in_run", 32'(val), 1);
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) check("timeout", 0, 1);
    if (cut_mode == 1) begin
      #2 srst = 1'b1;
      #1;
      check("rst_ready", 32'(cnt_ready), 1);
      check("rst_val", 32'(val), 0);
      check("rst_last", 32'(last), 0);
      check("rst_data", 32'(data), 0);
      q.delete();
      @(negedge clk);
      srst  = 1'b0;
      ready = 1'b0;
    end else if (cut_mode == 2) begin
`ifdef BIT_POP_GEN_ABORT_EN
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      ready = 1'b0;
      check("abort_val", 32'(val), 0);
      check("abort_last", 32'(last), 0);
      check("abort_ready", 32'(cnt_ready), 1);
      q.delete();
`endif
    end else begin
      @(negedge clk);
      ready = 1'b0;
      check("end_val", 32'(val), 0);
      check("end_last", 32'(last), 0);
      check("end_ready", 32'(cnt_ready), 1);
      check("queue_empty", q.size(), 0);
    end
  endtask

  logic [3:0] q4[$];

  initial begin
    srst     = 1'b1;
    cnt      = '0;
    cnt_val  = 1'b0;
    ready    = 1'b0;
    cnt4     = '0;
    cnt_val4 = 1'b0;
    ready4   = 1'b0;
`ifdef BIT_POP_GEN_ABORT_EN
    abort  = 1'b0;
    abort4 = 1'b0;
`endif
    #1;
    check("reset_ready", 32'(cnt_ready), 1);
    check("reset_val", 32'(val), 0);
    check("reset_last", 32'(last), 0);
    check("reset_data", 32'(data), 0);
    check("reset4_ready", 32'(cnt_ready4), 1);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);

    // WIDTH=4, k=2 at full throughput
    cnt4     = 3'd2;
    cnt_val4 = 1'b1;
    ready4   = 1'b1;
    q4 = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    @(negedge clk);
    cnt_val4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("w4_val", 32'(val4), 1);
      check("w4_word", 32'(data4), 32'(q4.pop_front()));
      check("w4_last", 32'(last4), (i == 5) ? 1 : 0);
      @(negedge clk);
    end
    ready4 = 1'b0;
    check("w4_end_ready", 32'(cnt_ready4), 1);
    check("w4_end_val", 32'(val4), 0);

    run_seq(0, 0, 0, -1, 0);
    run_seq(16, 0, 0, -1, 0);
    run_seq(20, 0, 0, -1, 0);
    run_seq(5, 0, 0, -1, 0);
    run_seq(8, 1, 0, -1, 0);

    // cnt_val held high and cnt_i wandering during RUN, then a follow-on request
    run_seq(3, 1, 1, -1, 0);
    run_seq(1, 0, 0, -1, 0);

    // asynchronous reset while word 5 of k=3 is presented
    run_seq(3, 0, 0, 4, 1);
    run_seq(1, 0, 0, -1, 0);

`ifdef BIT_POP_GEN_ABORT_EN
    run_seq(2, 0, 0, 1, 2);
    run_seq(1, 0, 0, -1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
